// File: rtl/req_capture_encoder_pkg.sv
// Shared constants, FSM state type and the priority-select function for the request capture front end.
// The priority order here matches the downstream 4-to-2 encoder, so both stages agree.
package req_capture_encoder_pkg;

    localparam int N_REQ    = 4;
    localparam int ID_W_REQ = 2;
    localparam int MAX_REQ  = 32;
    localparam int SEL_W    = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    typedef struct packed {
        logic             any;
        logic [SEL_W-1:0] idx;
    } prio_t;

    // The highest set index wins because later loop iterations overwrite earlier ones.
    function automatic prio_t prio_sel(input logic [MAX_REQ-1:0] vec);
        prio_t r;
        r.any = 1'b0;
        r.idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (vec[i]) begin
                r.any = 1'b1;
                r.idx = SEL_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/req_capture_encoder_edge.sv
// Event generation from the raw request lines: either a rising-edge detect or a pass-through of the level.
module req_edge_detect #(
    parameter int N    = 4,
    parameter bit EDGE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    output logic [N-1:0] ev
);

    generate
        if (EDGE) begin : g_edge
            logic [N-1:0] req_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    req_q <= '0;
                end else begin
                    req_q <= req_in;
                end
            end

            assign ev = req_in & ~req_q;
        end else begin : g_level
            assign ev = req_in;
        end
    endgenerate

endmodule

// File: rtl/req_capture_encoder.sv
// Sticky request capture with masked priority selection, presented downstream over valid/ready.
//   state   | meaning
//   IDLE    | nothing presented; waits for a masked-in pending bit
//   PRESENT | out_id/out_valid held stable until accepted
module req_capture_encoder
    import req_capture_encoder_pkg::*;
#(
    parameter int N    = N_REQ,
    parameter int ID_W = ID_W_REQ,
    parameter bit EDGE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_in,
    input  logic [N-1:0]    mask,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    input  logic            out_ready,
    output logic [N-1:0]    pending,
    output logic            overflow,
    input  logic            clr_ovf
);

    state_t       state;
    logic [N-1:0] ev;
    logic [N-1:0] clr;
    logic [N-1:0] pending_next;
    logic         accept;
    logic         ovf_set;
    prio_t        sel_now;
    prio_t        sel_after;

    req_edge_detect #(
        .N    (N),
        .EDGE (EDGE)
    ) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_in (req_in),
        .ev     (ev)
    );

    assign accept = out_valid && out_ready;

    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++) begin
            clr[i] = accept && (out_id == ID_W'(i));
        end
    end

    assign pending_next = (pending & ~clr) | ev;
    assign ovf_set      = |(ev & pending & ~clr);

    // The follow-on choice excludes the bit being accepted this cycle.
    assign sel_now   = prio_sel(MAX_REQ'(pending & mask));
    assign sel_after = prio_sel(MAX_REQ'(pending & ~clr & mask));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            overflow  <= 1'b0;
        end else begin
            pending <= pending_next;

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sel_now.any) begin
                        out_id    <= ID_W'(sel_now.idx);
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        if (sel_after.any) begin
                            out_id <= ID_W'(sel_after.idx);
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
